// File: rtl/hdmi_rx_cfg_seq.sv
// hdmi_rx_cfg_seq: ADV7611 reset and init-table sequencer sharing one I2C master
// with single manual read/write transactions while idle.
module hdmi_rx_cfg_seq #(
  parameter logic [11:0] TABLE_LEN = 12'h127,
  parameter int RST_HOLD = 50000,
  parameter int SWRST_WAIT = 300000,
  parameter int REQ_TIMEOUT = 1024
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        i2c_req,
  output logic        i2c_wr,
  output logic [7:0]  i2c_len,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_saddr,
  output logic [7:0]  i2c_tx,
  input  logic        i2c_busy,
  input  logic [7:0]  i2c_rx,
  input  logic        man_req,
  input  logic        man_wr,
  input  logic [6:0]  man_addr,
  input  logic [7:0]  man_saddr,
  input  logic [7:0]  man_data,
  output logic        man_ack,
  output logic [7:0]  man_rdata,
  output logic        rx_reset_n,
  output logic        active,
  output logic        done,
  output logic        err,
  output logic [11:0] index
);
  typedef enum logic [3:0] {
    IDLE, HOLD_RST, SWRST, SW_WAIT, FETCH, LOAD, REQ, XFER, MAN_REQ, MAN_XFER
  } state_e;
  localparam logic [18:0] RST_LAST = 19'(RST_HOLD - 1);
  localparam logic [18:0] SW_LAST  = 19'(SWRST_WAIT - 1);
  localparam logic [18:0] TO_LAST  = 19'(REQ_TIMEOUT - 1);
  state_e      state_q;
  logic [18:0] cnt_q;
  logic        boot_q, arm_q, sw_q;
  logic        req_st, timeout, fin_tbl, fin_man;
  logic [11:0] index_nx;
  assign req_st   = state_q == REQ || state_q == MAN_REQ;
  assign timeout  = req_st && i2c_req && !i2c_busy && cnt_q == TO_LAST;
  // A timed-out request completes exactly like a transfer whose busy fell.
  assign fin_tbl  = (state_q == XFER && !i2c_busy) || (state_q == REQ && timeout);
  assign fin_man  = (state_q == MAN_XFER && !i2c_busy) || (state_q == MAN_REQ && timeout);
  assign index_nx = index + 12'd1;
  assign rom_addr = index;
  assign i2c_len  = 8'd1;
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      boot_q     <= 1'b1;
      arm_q      <= 1'b1;
      sw_q       <= 1'b0;
      i2c_req    <= 1'b0;
      i2c_wr     <= 1'b1;
      i2c_addr   <= '0;
      i2c_saddr  <= '0;
      i2c_tx     <= '0;
      rx_reset_n <= 1'b1;
      man_ack    <= 1'b0;
      man_rdata  <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      index      <= '0;
    end else begin
      man_ack <= 1'b0;
      if (!man_req) arm_q <= 1'b1;
      // A master left busy by an earlier reset must go idle before a new request.
      if (req_st) begin
        if (!i2c_req) begin
          if (!i2c_busy) begin
            i2c_req <= 1'b1;
            cnt_q   <= '0;
          end
        end else if (i2c_busy) begin
          i2c_req <= 1'b0;
          state_q <= (state_q == REQ) ? XFER : MAN_XFER;
        end else if (timeout) begin
          i2c_req <= 1'b0;
          err     <= 1'b1;
        end else cnt_q <= cnt_q + 19'd1;
      end
      if (fin_tbl) begin
        if (sw_q) begin
          state_q <= SW_WAIT;
          cnt_q   <= '0;
        end else begin
          index   <= index_nx;
          state_q <= (index_nx == TABLE_LEN) ? IDLE : FETCH;
          if (index_nx == TABLE_LEN) begin
            done   <= 1'b1;
            active <= 1'b0;
          end
        end
      end
      if (fin_man) begin
        if (!i2c_wr) man_rdata <= i2c_rx;
        man_ack <= 1'b1;
        state_q <= IDLE;
      end
      case (state_q)
        IDLE:
          if (boot_q || start) begin
            state_q    <= HOLD_RST;
            boot_q     <= 1'b0;
            cnt_q      <= '0;
            rx_reset_n <= 1'b0;
            active     <= 1'b1;
            done       <= 1'b0;
            index      <= '0;
          end else if (man_req && arm_q) begin
            arm_q     <= 1'b0;
            i2c_wr    <= man_wr;
            i2c_addr  <= man_addr;
            i2c_saddr <= man_saddr;
            i2c_tx    <= man_data;
            state_q   <= MAN_REQ;
          end
        HOLD_RST:
          if (cnt_q == RST_LAST) begin
            rx_reset_n <= 1'b1;
            state_q    <= SWRST;
          end else cnt_q <= cnt_q + 19'd1;
        SWRST: begin
          i2c_wr    <= 1'b1;
          i2c_addr  <= 7'h4C;
          i2c_saddr <= 8'hFF;
          i2c_tx    <= 8'h80;
          sw_q      <= 1'b1;
          state_q   <= REQ;
        end
        SW_WAIT:
          if (cnt_q == SW_LAST) state_q <= FETCH;
          else cnt_q <= cnt_q + 19'd1;
        FETCH: state_q <= LOAD;
        LOAD:
          if (rom_data == 24'd0) begin
            done    <= 1'b1;
            active  <= 1'b0;
            state_q <= IDLE;
          end else begin
            i2c_wr    <= 1'b1;
            i2c_addr  <= rom_data[23:17];
            i2c_saddr <= rom_data[15:8];
            i2c_tx    <= rom_data[7:0];
            sw_q      <= 1'b0;
            state_q   <= REQ;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hdmi_rx_cfg_seq.sv
// tb_hdmi_rx_cfg_seq: directed and randomized bench with an I2C master model
// and a table-walk reference model for hdmi_rx_cfg_seq.
module tb_hdmi_rx_cfg_seq;
  localparam logic [11:0] TL = 12'd3;
  logic clk_50 = 1'b0, reset = 1'b1, start = 1'b0;
  logic [11:0] rom_addr, index;
  logic [23:0] rom_data = '0;
  logic i2c_req, i2c_wr, i2c_busy = 1'b0;
  logic [7:0] i2c_len, i2c_saddr, i2c_tx, i2c_rx = '0;
  logic [6:0] i2c_addr;
  logic man_req = 1'b0, man_wr = 1'b1;
  logic [6:0] man_addr = '0;
  logic [7:0] man_saddr = '0, man_data = '0, man_rdata;
  logic man_ack, rx_reset_n, active, done, err;

  hdmi_rx_cfg_seq #(.TABLE_LEN(TL), .RST_HOLD(10), .SWRST_WAIT(20), .REQ_TIMEOUT(8)) dut (
    .clk_50(clk_50), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_len(i2c_len), .i2c_addr(i2c_addr),
    .i2c_saddr(i2c_saddr), .i2c_tx(i2c_tx), .i2c_busy(i2c_busy), .i2c_rx(i2c_rx),
    .man_req(man_req), .man_wr(man_wr), .man_addr(man_addr), .man_saddr(man_saddr),
    .man_data(man_data), .man_ack(man_ack), .man_rdata(man_rdata), .rx_reset_n(rx_reset_n),
    .active(active), .done(done), .err(err), .index(index)
  );

  always #5 clk_50 = ~clk_50;

  logic [23:0] rom [0:3];
  always @(posedge clk_50) rom_data <= (rom_addr < 12'd4) ? rom[rom_addr[1:0]] : 24'd0;

  // I2C master model: accepts a request after it is idle, rises busy after m_lat
  // cycles and holds it for m_len cycles; every accepted transfer is logged.
  int m_lat = 1, m_len = 5, m_dly = 0, m_run = 0;
  bit resp_en = 1'b1;
  logic [7:0] rx_byte = '0;
  logic [23:0] log_q [$];
  always @(posedge clk_50) begin
    if (m_run > 0) begin
      m_run <= m_run - 1;
      if (m_run == 1) i2c_busy <= 1'b0;
    end else if (m_dly > 0) begin
      m_dly <= m_dly - 1;
      if (m_dly == 1) begin
        i2c_busy <= 1'b1;
        m_run    <= m_len;
      end
    end else if (i2c_req && resp_en && !i2c_busy) begin
      log_q.push_back({i2c_wr, i2c_addr, i2c_saddr, i2c_tx});
      i2c_rx <= rx_byte;
      m_dly  <= m_lat;
    end
  end

  int low_cnt = 0, req_run = 0, last_run = 0;
  always @(posedge clk_50) begin
    if (!rx_reset_n) low_cnt++;
    if (i2c_req) req_run++;
    else if (req_run != 0) begin
      last_run = req_run;
      req_run  = 0;
    end
  end

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the software-reset write, then table entries up to an all-zero
  // word or TABLE_LEN entries; returns the final table index.
  logic [23:0] exp_q [$];
  function automatic int build_exp();
    exp_q = {};
    exp_q.push_back({1'b1, 7'h4C, 8'hFF, 8'h80});
    for (int i = 0; i < int'(TL); i++) begin
      if (rom[i] == 24'd0) return i;
      exp_q.push_back({1'b1, rom[i][23:17], rom[i][15:8], rom[i][7:0]});
    end
    return int'(TL);
  endfunction

  task automatic cmp_log(input string tag, input int base);
    check({tag, "_cnt"}, log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), log_q[base + i], exp_q[i]);
  endtask

  task automatic wait_seq(input string tag);
    int n = 0;
    while (!active && n < 10) begin @(negedge clk_50); n++; end
    while (active && n < 5000) begin @(negedge clk_50); n++; end
    check({tag, "_finished"}, n < 5000, 1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!man_ack && n < 500) begin @(negedge clk_50); n++; end
    check({tag, "_ack_seen"}, man_ack, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk_50) start = 1'b1;
    @(negedge clk_50) start = 1'b0;
  endtask

  initial begin
    int base, snap, n, ei;
    rom[0] = 24'h980106; rom[1] = 24'h9802F5; rom[2] = 24'h444840; rom[3] = 24'h0;
    repeat (3) @(negedge clk_50);
    check("rst_req", i2c_req, 0);
    check("rst_wr_len", {i2c_wr, i2c_len}, {1'b1, 8'd1});
    check("rst_regs", {i2c_addr, i2c_saddr, i2c_tx}, 0);
    check("rst_flags", {rx_reset_n, active, done, err, man_ack}, 5'b10000);
    check("rst_idx", {index, rom_addr, man_rdata}, 0);

    snap = low_cnt; base = log_q.size(); ei = build_exp();
    reset = 1'b0;
    n = 0; while (!i2c_busy && n < 100) begin @(negedge clk_50); n++; end
    n = 0; while (i2c_busy && n < 100) begin @(negedge clk_50); n++; end
    check("sw_first", log_q.size() > base ? log_q[base] : 24'd0, 24'hCCFF80);
    n = 0; while (!i2c_req && n < 100) begin @(negedge clk_50); n++; end
    check("sw_wait_gap", n >= 22 && n <= 26, 1);
    wait_seq("boot");
    check("boot_low", low_cnt - snap, 10);
    cmp_log("boot", base);
    check("boot_state", {done, active, err, index}, {3'b100, 12'(ei)});

    rx_byte = 8'h20; base = log_q.size();
    @(negedge clk_50);
    man_wr = 1'b0; man_addr = 7'h4C; man_saddr = 8'hEA; man_data = 8'h55; man_req = 1'b1;
    wait_ack("mrd");
    check("mrd_rdata", man_rdata, 8'h20);
    check("mrd_wr", i2c_wr, 0);
    @(negedge clk_50);
    check("mrd_ack_width", man_ack, 0);
    repeat (30) @(negedge clk_50);
    check("mrd_once", log_q.size() - base, 1);
    check("mrd_txn", log_q[base], {1'b0, 7'h4C, 8'hEA, 8'h55});
    man_req = 1'b0;

    rom[1] = 24'h0; base = log_q.size(); ei = build_exp();
    pulse_start();
    wait_seq("endm");
    cmp_log("endm", base);
    check("endm_state", {done, index}, {1'b1, 12'd1});

    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 3; i++)
        rom[i] = ($urandom_range(0, 4) == 0) ? 24'd0 : 24'($urandom) | 24'h020000;
      m_lat = $urandom_range(1, 3); m_len = $urandom_range(1, 6);
      base = log_q.size(); ei = build_exp();
      pulse_start();
      wait_seq($sformatf("rnd%0d", it));
      cmp_log($sformatf("rnd%0d", it), base);
      check($sformatf("rnd%0d_idx", it), {done, index}, {1'b1, 12'(ei)});
    end

    rom[0] = 24'h980106; rom[1] = 24'h9802F5; rom[2] = 24'h444840;
    base = log_q.size(); ei = build_exp();
    @(negedge clk_50);
    man_wr = 1'b1; man_addr = 7'($urandom); man_saddr = 8'($urandom); man_data = 8'($urandom);
    man_req = 1'b1; start = 1'b1;
    @(negedge clk_50) start = 1'b0;
    wait_seq("prio");
    cmp_log("prio", base);
    wait_ack("prio_man");
    check("prio_man_txn", log_q[log_q.size() - 1], {1'b1, man_addr, man_saddr, man_data});
    @(negedge clk_50) man_req = 1'b0;

    resp_en = 1'b0; base = log_q.size();
    check("to_err_clear", err, 0);
    pulse_start();
    wait_seq("to");
    check("to_err", err, 1);
    check("to_req_len", last_run, 8);
    check("to_advance", {done, index}, {1'b1, TL});
    check("to_nolog", log_q.size() - base, 0);

    @(negedge clk_50) reset = 1'b1;
    @(negedge clk_50);
    @(negedge clk_50);
    check("rerst_err", {err, i2c_req, done}, 0);
    resp_en = 1'b1; base = log_q.size(); ei = build_exp();
    reset = 1'b0;
    wait_seq("rerst");
    cmp_log("rerst", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hdmi_rx_cfg_seq.md
Name: hdmi_rx_cfg_seq

Overview:
Controller for the ADV7611 HDMI receiver's configuration path. It sequences the receiver's hardware reset and an I2C software reset, then replays a register table from a synchronous ROM through the shared I2C master. When the sequence is idle, it arbitrates single manual read/write transactions (switches/keys) onto the same master. It sits between the top level, the init ROM and the I2C master.

Parameters:
TABLE_LEN, 12'h127, number of table entries; ROM indices 0..TABLE_LEN-1
RST_HOLD, 50000, cycles rx_reset_n is held low (1 ms at 50 MHz)
SWRST_WAIT, 300000, cycles waited after the I2C software-reset write (6 ms)
REQ_TIMEOUT, 1024, maximum cycles i2c_req may wait for i2c_busy

Ports:
clk_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
start  in  1  pulse: rerun the full configuration sequence
rom_addr  out  12  init ROM read index
rom_data  in  24  {dev_addr[23:17], unused[16], sub_addr[15:8], data[7:0]}; valid 1 cycle after rom_addr
i2c_req  out  1  request to I2C master
i2c_wr  out  1  1=write, 0=read
i2c_len  out  8  byte count, always 1
i2c_addr  out  7  device address
i2c_saddr  out  8  sub-address
i2c_tx  out  8  write byte
i2c_busy  in  1  I2C master busy
i2c_rx  in  8  I2C read byte
man_req  in  1  manual request; held until man_ack
man_wr  in  1  manual direction
man_addr  in  7  manual device address
man_saddr  in  8  manual sub-address
man_data  in  8  manual write byte
man_ack  out  1  1-cycle pulse: manual transaction finished
man_rdata  out  8  last manual read byte
rx_reset_n  out  1  ADV7611 reset, active low
active  out  1  configuration sequence in progress
done  out  1  table completed since last start/reset
err  out  1  sticky: request timeout seen
index  out  12  current table index (for LED/HEX display)

Behaviour:
- Reset values: i2c_req=0, i2c_wr=1, i2c_len=1, i2c_addr=0, i2c_saddr=0, i2c_tx=0, rx_reset_n=1, man_ack=0, man_rdata=0, active=0, done=0, err=0, index=0, rom_addr=0, state=IDLE.
- Auto-start: in the first cycle after reset deasserts, the FSM enters HOLD_RST. In IDLE, start re-enters HOLD_RST. start is ignored while active=1.
- States: IDLE, HOLD_RST, SWRST, SW_WAIT, FETCH, LOAD, REQ, XFER, MAN_REQ, MAN_XFER.
- HOLD_RST: rx_reset_n=0 and active=1 for RST_HOLD cycles; done and index are cleared; then go to SWRST.
- SWRST: load addr=7'h4C, saddr=8'hFF, tx=8'h80, wr=1; go to REQ with return target SW_WAIT.
- SW_WAIT: count SWRST_WAIT cycles, then go to FETCH.
- FETCH: rom_addr=index. LOAD, one cycle later: latch rom_data fields into the i2c_* registers with wr=1. An all-zero rom_data word is an end marker: go to IDLE and set done=1.
- REQ: assert i2c_req and hold it until the first cycle i2c_busy=1, then deassert the next cycle and go to XFER. If busy is not seen within REQ_TIMEOUT cycles: set err=1, drop i2c_req, and skip the transaction (advance as if it completed).
- XFER: wait for i2c_busy=0. Table path: index+1; if the new index equals TABLE_LEN, set done=1, active=0 and go to IDLE; otherwise go to FETCH.
- i2c_* address/data registers are stable from LOAD until XFER exits.
- Manual path: only in IDLE with man_req=1 (the sequence always has priority). Latch the man_* fields, then go to MAN_REQ; MAN_REQ uses the same handshake and timeout rules as REQ.
- Manual completion: on busy falling in MAN_XFER, capture i2c_rx into man_rdata if man_wr=0, pulse man_ack for 1 cycle, and return to IDLE. man_req must drop before a second transaction is accepted (edge re-arm).
- Simultaneous start and man_req in IDLE: start wins; man_req stays pending.
- reset mid-transaction returns to IDLE at once and drops i2c_req; the I2C master is not aborted. The next sequence's REQ waits for i2c_busy=0 before asserting.
- Counters are 19-bit and saturate-free; index never wraps because it terminates at TABLE_LEN.

Test Plan:
- Reset release, RST_HOLD=10, SWRST_WAIT=20, busy model 5 cycles -> rx_reset_n low for exactly 10 cycles; first transfer is addr 4C/FF/80; FETCH begins 20 cycles after that busy falls.
- ROM of 3 entries (98 01 06, 98 02 F5, 44 48 40), TABLE_LEN=3 -> three writes in order; done=1 and active=0 the cycle after the third busy falls; index=3.
- Entry 1 = 24'h000000 with TABLE_LEN=3 -> only entry 0 is sent; done=1; index=1.
- busy never asserts, REQ_TIMEOUT=8 -> i2c_req high for 8 cycles; err=1; sequence advances to the next entry.
- man_req read addr 4C saddr EA while done=1, model returns 0x20 -> man_rdata=0x20; one-cycle man_ack; i2c_wr=0.
- man_req asserted during the table sequence -> not served until IDLE; start and man_req in the same IDLE cycle -> sequence runs first, then the manual transaction.
